// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the GMII receive FSM encoding.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    // The serial CRC shifts LSB-first, so it needs the polynomial bit-reversed.
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (reflected) update for one byte, data bits taken LSB-first.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] poly_refl;
    logic [31:0] c;

    assign poly_refl = bit_rev32(CRC_POLY);

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ poly_refl;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive front end: strips preamble/SFD, checks and removes FCS,
// frames the byte stream with sof/eof/good/len and keeps receive statistics.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | between frames, waiting for dv with a preamble byte
// PREAMBLE | counting 0x55 bytes, waiting for the SFD
// DATA     | frame body: CRC, byte count, 5-deep delay line; dv low flushes
// DROP     | bad start seen, discard until dv drops
module gmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int MIN_LEN      = 60,
    parameter int MAX_LEN      = 1514,
    parameter int MIN_PREAMBLE = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_good,
    output logic [10:0] rx_len,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_crc_err,
    output logic [31:0] stat_len_err,
    output logic [31:0] stat_pre_err
);

    rx_state_t   state, state_nxt;
    logic [7:0]  rxd_q;
    logic        dv_q;
    logic [2:0]  pre_cnt;
    logic [31:0] crc_q, crc_nxt;
    logic [11:0] byte_cnt;
    logic [7:0]  dl [0:4];

    logic        pre_load, pre_inc, start, take, flush, pre_err;
    logic [11:0] len12;
    logic [10:0] len_sat;
    logic        len_bad, crc_ok, line_full;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (rxd_q),
        .crc_out (crc_nxt)
    );

    // Data length is everything received minus the 4 FCS bytes still in the delay line.
    assign len12     = byte_cnt - 12'd4;
    assign len_sat   = (len12 > 12'd2047) ? 11'h7FF : len12[10:0];
    assign len_bad   = (byte_cnt < 12'd5) || (int'(len12) < MIN_LEN) || (int'(len12) > MAX_LEN);
    assign crc_ok    = (crc_q == CRC_RESIDUE);
    assign line_full = (byte_cnt >= 12'd5);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_load  = 1'b0;
        pre_inc   = 1'b0;
        start     = 1'b0;
        take      = 1'b0;
        flush     = 1'b0;
        pre_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dv_q) begin
                    if (rxd_q == PREAMBLE_BYTE) begin
                        state_nxt = ST_PREAMBLE;
                        pre_load  = 1'b1;
                    end else begin
                        state_nxt = ST_DROP;
                        pre_err   = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_nxt = ST_IDLE;
                end else if (rxd_q == PREAMBLE_BYTE) begin
                    pre_inc = 1'b1;
                end else if (rxd_q == SFD_BYTE && int'(pre_cnt) >= MIN_PREAMBLE) begin
                    state_nxt = ST_DATA;
                    start     = 1'b1;
                end else begin
                    state_nxt = ST_DROP;
                    pre_err   = 1'b1;
                end
            end
            ST_DATA: begin
                if (dv_q) begin
                    take = 1'b1;
                end else begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!dv_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rxd_q          <= 8'h00;
            dv_q           <= 1'b0;
            pre_cnt        <= 3'd0;
            crc_q          <= CRC_INIT;
            byte_cnt       <= 12'd0;
            for (int i = 0; i < 5; i++) begin
                dl[i] <= 8'h00;
            end
            rx_data        <= 8'h00;
            rx_valid       <= 1'b0;
            rx_sof         <= 1'b0;
            rx_eof         <= 1'b0;
            rx_good        <= 1'b0;
            rx_len         <= 11'd0;
            stat_frames_ok <= 32'd0;
            stat_crc_err   <= 32'd0;
            stat_len_err   <= 32'd0;
            stat_pre_err   <= 32'd0;
        end else begin
            rxd_q    <= gmii_rxd;
            dv_q     <= gmii_rx_dv;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_good  <= 1'b0;
            rx_len   <= 11'd0;

            if (pre_load) begin
                pre_cnt <= 3'd1;
            end else if (pre_inc && pre_cnt != 3'd7) begin
                pre_cnt <= pre_cnt + 3'd1;
            end

            if (start) begin
                crc_q    <= CRC_INIT;
                byte_cnt <= 12'd0;
            end

            if (take) begin
                crc_q <= crc_nxt;
                if (byte_cnt != 12'hFFF) begin
                    byte_cnt <= byte_cnt + 12'd1;
                end
                dl[0] <= rxd_q;
                for (int i = 1; i < 5; i++) begin
                    dl[i] <= dl[i-1];
                end
                // A new byte proves the oldest one is not FCS, so it can leave.
                if (line_full) begin
                    rx_data  <= dl[4];
                    rx_valid <= 1'b1;
                    rx_sof   <= (byte_cnt == 12'd5);
                end
            end

            if (flush) begin
                if (line_full) begin
                    rx_data  <= dl[4];
                    rx_valid <= 1'b1;
                    rx_sof   <= (byte_cnt == 12'd5);
                    rx_eof   <= 1'b1;
                    rx_good  <= !len_bad && crc_ok;
                    rx_len   <= len_sat;
                end
                if (len_bad) begin
                    stat_len_err <= stat_len_err + 32'd1;
                end else if (!crc_ok) begin
                    stat_crc_err <= stat_crc_err + 32'd1;
                end else begin
                    stat_frames_ok <= stat_frames_ok + 32'd1;
                end
            end

            if (pre_err) begin
                stat_pre_err <= stat_pre_err + 32'd1;
            end
        end
    end

endmodule

// File: doc/gmii_rx_deframer.md
Name: gmii_rx_deframer

Overview:
- Per-port GMII receive front end; sits directly downstream of a gmii_N_rxd / gmii_N_rx_dv pin pair and upstream of the switching/lookup logic inside system.
- Strips preamble and SFD, checks FCS with CRC-32, removes the 4 FCS bytes, and delivers a byte stream framed with sof/eof plus a good/bad verdict.
- Maintains per-port receive statistics counters.

Parameters:
- MIN_LEN, 60, minimum data length in bytes (excluding FCS) for a frame to be counted good.
- MAX_LEN, 1514, maximum data length in bytes (excluding FCS) for a frame to be counted good.
- MIN_PREAMBLE, 1, minimum number of 0x55 bytes required before the SFD.

Ports:
- sys_clk  in  1  — single clock; GMII RX clock domain.
- sys_rst  in  1  — asynchronous, active-high reset.
- gmii_rxd  in  8  — GMII receive data.
- gmii_rx_dv  in  1  — GMII receive data valid.
- rx_data  out  8  — frame byte (destination MAC first; FCS excluded).
- rx_valid  out  1  — rx_data is valid this cycle.
- rx_sof  out  1  — first data byte of the frame; qualified by rx_valid.
- rx_eof  out  1  — last data byte of the frame; qualified by rx_valid.
- rx_good  out  1  — meaningful only with rx_eof: CRC ok and MIN_LEN <= length <= MAX_LEN.
- rx_len  out  11  — data byte count of the frame; valid with rx_eof; saturates at 2047.
- stat_frames_ok  out  32  — count of good frames.
- stat_crc_err  out  32  — count of frames with length ok but bad CRC.
- stat_len_err  out  32  — count of runt or giant frames, regardless of CRC.
- stat_pre_err  out  32  — count of bad-preamble aborts.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, delay line cleared, CRC register set to 0xFFFFFFFF.
- Input stage: gmii_rxd and gmii_rx_dv are registered once (rxd_q, dv_q). The FSM operates only on these registered values.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: dv_q=1 and rxd_q=0x55 -> PREAMBLE with pre_cnt=1. dv_q=1 and any other byte -> DROP, incrementing stat_pre_err.
  - PREAMBLE:
    - rxd_q=0x55 -> stay; pre_cnt increments and saturates at 7.
    - rxd_q=0xD5 and pre_cnt>=MIN_PREAMBLE -> DATA; CRC register = 0xFFFFFFFF, byte count = 0.
    - Any other byte, or 0xD5 too early -> DROP, incrementing stat_pre_err.
    - dv_q=0 -> IDLE with no counter change.
  - DATA: each byte with dv_q=1 updates the CRC, increments the byte count, and shifts into a 5-entry delay line. dv_q=0 -> flush, then IDLE.
  - DROP: wait for dv_q=0 -> IDLE. No output is produced.
- Output timing:
  - A byte sampled on gmii_rxd at edge n appears on rx_data with rx_valid=1 after edge n+6, provided 4 later bytes exist. The delay line therefore always withholds the final 4 bytes, which are the FCS.
  - When the first dv_q=0 is seen in DATA, the oldest delay-line entry (the last data byte) is emitted with rx_eof=1. rx_good and rx_len are valid in that same cycle, and the appropriate statistic is incremented in that cycle.
  - rx_sof is asserted with the first emitted byte. A frame of exactly 5 bytes after the SFD emits a single byte with sof=eof=1, good=0, and increments stat_len_err.
  - 1-4 bytes after the SFD: no output, stat_len_err increments, return to IDLE.
- CRC: reflected polynomial 0x04C11DB7, bits processed LSB-first, init 0xFFFFFFFF. It is computed over data and FCS. The frame's CRC is correct iff the register equals 0xDEBB20E3 after the last FCS byte.
- Verdict priority: a length error (len<MIN_LEN or len>MAX_LEN) takes priority; such a frame increments only stat_len_err. Otherwise a bad CRC increments stat_crc_err; otherwise stat_frames_ok increments.
- Giants are forwarded in full with rx_good=0; downstream discards them. rx_len saturates at 2047 and never wraps. Statistics counters wrap modulo 2^32.
- Back-to-back frames: a minimum of 1 dv-low cycle between frames is supported with no loss. The flush and the new preamble do not collide.
- Reset mid-frame: outputs drop to 0 immediately. If dv is still high when reset releases, the frame remainder is treated as a bad start: DROP, and stat_pre_err increments.
- No backpressure: the consumer must accept 1 byte per clock.

Decomposition:
- Package eth_pkg holds:
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - CRC_POLY=32'h04C11DB7, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3;
  - the FSM state encoding.
- Sub-module crc32_d8: combinational next-CRC function, 32-bit state in, 8-bit data in, 32-bit state out. It is reused later by the TX framer.

Test Plan:
- 7x55, D5, 60-byte frame + correct FCS -> 60 rx_valid beats; sof on byte 0, eof on byte 59; rx_good=1, rx_len=60; stat_frames_ok=1; first beat appears 6 edges after the first data byte is sampled.
- Same frame with byte 20 bit-flipped -> eof with rx_good=0, rx_len=60; stat_crc_err=1, stat_frames_ok unchanged.
- 40-byte frame + valid FCS -> rx_good=0, rx_len=40; stat_len_err=1. A 1515-byte frame -> rx_good=0; stat_len_err=2.
- Preamble 55,55,AA,... -> no rx_valid for the whole burst; stat_pre_err=1. A burst starting directly with D5 -> stat_pre_err=2.
- Two good 64-byte frames separated by 1 dv-low cycle -> two complete sof..eof sequences with no byte lost; stat_frames_ok=2.
- sys_rst pulsed at data byte 30 of a frame -> outputs 0 during reset; remainder dropped; stat_pre_err=1 (counters were reset, then this increment); the following good frame is received normally.
